keypad_scanner: RTL and testbench

- Front end for the 4x4 matrix keypad. Drives the column lines one at a time, reads the row lines, and debounces both press and release.
- On each debounced press it presents a 4-bit key code on keypadInput and pulses keyPressEvent for one clock.
- It is the producer of the keyPressEvent/keypadInput pair that the stock/purchase logic consumes on the rising edge of keyPressEvent.
- Sits between the board keypad pins and the vending-machine control logic.

---
 rtl/keypad_pkg.sv | 26 ++
 rtl/keypad_tick_gen.sv | 29 ++
 rtl/keypad_scanner.sv | 179 +++++++++++++++++
 tb/tb_keypad_scanner.sv | 168 ++++++++++++++++
 4 files changed

// File: rtl/keypad_pkg.sv
// keypad_pkg: shared types, key map and defaults for the 4x4 keypad scanner
package keypad_pkg;

    typedef enum logic [1:0] {SCAN, DEBOUNCE, HELD} state_t;

    localparam int DEF_SCAN_DIV       = 100000;
    localparam int DEF_DEBOUNCE_SCANS = 4;
    localparam int DEF_REPEAT_DELAY   = 500;
    localparam int DEF_REPEAT_RATE    = 100;

    // Column drive right after reset: column 0 pulled low
    localparam logic [3:0] COL_IDLE = 4'b1110;

    // KEY_CODE[row][col]
    localparam logic [3:0] KEY_CODE [4][4] = '{
        '{4'h1, 4'h2, 4'h3, 4'hA},
        '{4'h4, 4'h5, 4'h6, 4'hB},
        '{4'h7, 4'h8, 4'h9, 4'hC},
        '{4'h0, 4'hF, 4'hE, 4'hD}
    };

    function automatic logic [3:0] key_code(input logic [1:0] r, input logic [1:0] c);
        return KEY_CODE[r][c];
    endfunction

endpackage

// File: rtl/keypad_tick_gen.sv
// keypad_tick_gen: column dwell counter, one-cycle tick at the end of each dwell
module keypad_tick_gen
    import keypad_pkg::*;
#(
    parameter int SCAN_DIV = DEF_SCAN_DIV
) (
    input  logic clk,
    input  logic rst,
    output logic tick
);

    localparam int W = $clog2(SCAN_DIV);
    localparam logic [W-1:0] LAST = W'(SCAN_DIV - 1);

    logic [W-1:0] cnt_q, cnt_d;

    // Wrap at SCAN_DIV-1 and flag that cycle as the sample tick
    always_comb begin
        tick  = (cnt_q == LAST);
        cnt_d = tick ? '0 : cnt_q + 1'b1;
    end

    // Dwell counter register
    always_ff @(posedge clk) begin
        if (rst) cnt_q <= '0;
        else     cnt_q <= cnt_d;
    end

endmodule

// File: rtl/keypad_scanner.sv
// keypad_scanner: 4x4 keypad column scan with press/release debounce.
// Define KEYPAD_REPEAT_EN to enable auto-repeat of keyPressEvent while a key is held.
module keypad_scanner
    import keypad_pkg::*;
#(
    parameter int SCAN_DIV       = DEF_SCAN_DIV,
    parameter int DEBOUNCE_SCANS = DEF_DEBOUNCE_SCANS,
    parameter int REPEAT_DELAY   = DEF_REPEAT_DELAY,
    parameter int REPEAT_RATE    = DEF_REPEAT_RATE
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] row,
    output logic [3:0] col,
    output logic [3:0] keypadInput,
    output logic       keyPressEvent,
    output logic       keyHeld
);

`ifdef KEYPAD_REPEAT_EN
    localparam bit REP_EN = 1'b1;
`else
    localparam bit REP_EN = 1'b0;
`endif

    localparam int DW = $clog2(DEBOUNCE_SCANS + 1);
    localparam logic [DW-1:0] DS_C = DW'(DEBOUNCE_SCANS);
    localparam int REP_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
    localparam int RW = $clog2(REP_MAX + 1);
    localparam logic [RW-1:0] REP_MAX_C = RW'(REP_MAX);
    localparam logic [RW-1:0] RD_C = RW'(REPEAT_DELAY);
    localparam logic [RW-1:0] RR_C = RW'(REPEAT_RATE);

    state_t        state_q, state_d;
    logic [3:0]    sync1_q, sync2_q;
    logic [1:0]    col_q, col_d;
    logic [1:0]    cand_q, cand_d;
    logic [DW-1:0] deb_q, deb_d, rel_q, rel_d;
    logic [RW-1:0] rep_q, rep_d;
    logic          rep_first_q, rep_first_d;
    logic [3:0]    code_q, code_d;
    logic          evt_q, evt_d;
    logic          held_q, held_d;
    logic          tick, any_low, accept, rel_done, rep_fire;
    logic [1:0]    win;
    logic [DW-1:0] deb_inc, rel_inc;
    logic [RW-1:0] rep_inc;

    keypad_tick_gen #(.SCAN_DIV(SCAN_DIV)) u_tick (
        .clk  (clk),
        .rst  (rst),
        .tick (tick)
    );

    assign col           = ~(~COL_IDLE << col_q);
    assign keypadInput   = code_q;
    assign keyPressEvent = evt_q;
    assign keyHeld       = held_q;

    // Lowest low row wins; counters saturate at their bounds
    always_comb begin
        any_low = ~&sync2_q;
        win     = ~sync2_q[0] ? 2'd0 : ~sync2_q[1] ? 2'd1 : ~sync2_q[2] ? 2'd2 : 2'd3;
        deb_inc = (deb_q == DS_C) ? deb_q : deb_q + 1'b1;
        rel_inc = (rel_q == DS_C) ? rel_q : rel_q + 1'b1;
        rep_inc = (rep_q == REP_MAX_C) ? rep_q : rep_q + 1'b1;
    end

    // Row synchronizer plus state and output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q     <= 4'b1111;
            sync2_q     <= 4'b1111;
            state_q     <= SCAN;
            col_q       <= '0;
            cand_q      <= '0;
            deb_q       <= '0;
            rel_q       <= '0;
            rep_q       <= '0;
            rep_first_q <= 1'b1;
            code_q      <= '0;
            evt_q       <= 1'b0;
            held_q      <= 1'b0;
        end else begin
            sync1_q     <= row;
            sync2_q     <= sync1_q;
            state_q     <= state_d;
            col_q       <= col_d;
            cand_q      <= cand_d;
            deb_q       <= deb_d;
            rel_q       <= rel_d;
            rep_q       <= rep_d;
            rep_first_q <= rep_first_d;
            code_q      <= code_d;
            evt_q       <= evt_d;
            held_q      <= held_d;
        end
    end

    // Next state: act only on sample ticks; the column is frozen outside SCAN
    always_comb begin
        state_d     = state_q;
        col_d       = col_q;
        cand_d      = cand_q;
        deb_d       = deb_q;
        rel_d       = rel_q;
        rep_d       = rep_q;
        rep_first_d = rep_first_q;
        accept      = 1'b0;
        rel_done    = 1'b0;
        rep_fire    = 1'b0;
        if (tick) begin
            case (state_q)
                SCAN: begin
                    if (any_low) begin
                        cand_d = win;
                        if (DEBOUNCE_SCANS == 1) begin
                            accept  = 1'b1;
                            state_d = HELD;
                        end else begin
                            deb_d   = DW'(1);
                            state_d = DEBOUNCE;
                        end
                    end else begin
                        col_d = col_q + 2'd1;
                    end
                end
                DEBOUNCE: begin
                    if (any_low && win == cand_q) begin
                        deb_d = deb_inc;
                        if (deb_inc == DS_C) begin
                            accept  = 1'b1;
                            deb_d   = '0;
                            state_d = HELD;
                        end
                    end else begin
                        deb_d   = '0;
                        state_d = SCAN;
                    end
                end
                HELD: begin
                    if (sync2_q[cand_q]) begin
                        rel_d = rel_inc;
                        if (rel_inc == DS_C) begin
                            rel_done = 1'b1;
                            rel_d    = '0;
                            state_d  = SCAN;
                            col_d    = col_q + 2'd1;
                        end
                    end else begin
                        rel_d = '0;
                    end
                    if (REP_EN && !rel_done) begin
                        rep_d = rep_inc;
                        if (rep_inc == (rep_first_q ? RD_C : RR_C)) begin
                            rep_fire    = 1'b1;
                            rep_d       = '0;
                            rep_first_d = 1'b0;
                        end
                    end
                end
                default: state_d = SCAN;
            endcase
            if (accept) begin
                rel_d       = '0;
                rep_d       = '0;
                rep_first_d = 1'b1;
            end
        end
    end

    // Outputs: code and pulse register one cycle after the accepting tick
    always_comb begin
        code_d = accept ? key_code(cand_d, col_q) : code_q;
        evt_d  = accept | rep_fire;
        held_d = accept ? 1'b1 : rel_done ? 1'b0 : held_q;
    end

endmodule

// File: tb/tb_keypad_scanner.sv
// tb_keypad_scanner: directed bench for keypad_scanner (SCAN_DIV=4, DEBOUNCE_SCANS=3)
module tb_keypad_scanner;

    logic        clk;
    logic        rst;
    logic [3:0]  row;
    logic [3:0]  col;
    logic [3:0]  keypadInput;
    logic        keyPressEvent;
    logic        keyHeld;
    logic [15:0] keys;
    logic [31:0] m;
    int          n_run;
    int          n_fail;

    keypad_scanner #(
        .SCAN_DIV       (4),
        .DEBOUNCE_SCANS (3),
        .REPEAT_DELAY   (2),
        .REPEAT_RATE    (1)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .row           (row),
        .col           (col),
        .keypadInput   (keypadInput),
        .keyPressEvent (keyPressEvent),
        .keyHeld       (keyHeld)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Keypad matrix: a pressed key pulls its row low while its column is driven low
    always_comb begin
        for (int r = 0; r < 4; r++) row[r] = ~|(keys[r*4 +: 4] & ~col);
    end

    function automatic logic [15:0] kb(input int r, input int c);
        return 16'h1 << (4 * r + c);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_run++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    // Step n negedges, marking bit i when keyPressEvent is high at step i
    task automatic watch(input int n, output logic [31:0] mk);
        mk = '0;
        for (int i = 1; i <= n; i++) begin
            @(negedge clk);
            if (keyPressEvent) mk[i] = 1'b1;
        end
    endtask

    initial begin
        n_run  = 0;
        n_fail = 0;
        keys   = '0;
        rst    = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_col", 32'(col), 32'hE);
        chk("rst_code", 32'(keypadInput), 32'h0);
        chk("rst_evt", 32'(keyPressEvent), 32'h0);
        chk("rst_held", 32'(keyHeld), 32'h0);
        rst = 1'b0;
        watch(4, m);
        chk("rot_c1", 32'(col), 32'hD);
        watch(4, m);
        chk("rot_c2", 32'(col), 32'hB);
        watch(4, m);
        chk("rot_c3", 32'(col), 32'h7);
        watch(4, m);
        chk("rot_c0", 32'(col), 32'hE);
`ifdef KEYPAD_REPEAT_EN
        keys = kb(3, 0);
        watch(28, m);
        chk("rep_mask", m, (32'h1 << 12) | (32'h1 << 20) | (32'h1 << 24) | (32'h1 << 28));
        chk("rep_code", 32'(keypadInput), 32'h0);
        keys = '0;
        watch(12, m);
        chk("rep_rel_mask", m, (32'h1 << 4) | (32'h1 << 8));
        chk("rep_rel_held", 32'(keyHeld), 32'h0);
`else
        keys = kb(1, 1);
        watch(16, m);
        chk("p5_mask", m, 32'h1 << 16);
        chk("p5_code", 32'(keypadInput), 32'h5);
        chk("p5_col", 32'(col), 32'hD);
        chk("p5_held", 32'(keyHeld), 32'h1);
        watch(1, m);
        chk("p5_one_pulse", m, 32'h0);
        keys = '0;
        watch(10, m);
        chk("r5_mask", m, 32'h0);
        chk("r5_held_still", 32'(keyHeld), 32'h1);
        watch(1, m);
        chk("r5_held_fall", 32'(keyHeld), 32'h0);
        chk("r5_col_adv", 32'(col), 32'hB);
        keys = kb(0, 3);
        watch(12, m);
        chk("bnc_mask1", m, 32'h0);
        keys = '0;
        watch(4, m);
        chk("bnc_col_kept", 32'(col), 32'h7);
        chk("bnc_mask2", m, 32'h0);
        watch(4, m);
        chk("bnc_mask3", m, 32'h0);
        chk("bnc_col_rot", 32'(col), 32'hE);
        keys = kb(0, 3);
        watch(24, m);
        chk("pa_mask", m, 32'h1 << 24);
        chk("pa_code", 32'(keypadInput), 32'hA);
        keys = '0;
        watch(12, m);
        chk("ra_mask", m, 32'h0);
        chk("ra_held", 32'(keyHeld), 32'h0);
        chk("ra_col", 32'(col), 32'hE);
        keys = kb(0, 3) | kb(2, 3);
        watch(24, m);
        chk("prio_mask", m, 32'h1 << 24);
        chk("prio_code", 32'(keypadInput), 32'hA);
        keys = keys | kb(0, 0);
        watch(16, m);
        chk("roll_mask", m, 32'h0);
        chk("roll_held", 32'(keyHeld), 32'h1);
        chk("roll_col", 32'(col), 32'h7);
        keys = kb(0, 0);
        watch(12, m);
        chk("rprio_mask", m, 32'h0);
        chk("rprio_held", 32'(keyHeld), 32'h0);
        chk("rprio_col", 32'(col), 32'hE);
        watch(12, m);
        chk("p1_mask", m, 32'h1 << 12);
        chk("p1_code", 32'(keypadInput), 32'h1);
        chk("p1_held", 32'(keyHeld), 32'h1);
        keys = '0;
        watch(12, m);
        chk("r1_mask", m, 32'h0);
        chk("r1_held", 32'(keyHeld), 32'h0);
        chk("r1_col", 32'(col), 32'hD);
        keys = kb(3, 3);
        watch(15, m);
        chk("pd_mask", m, 32'h0);
        rst  = 1'b1;
        keys = '0;
        @(negedge clk);
        chk("mrst_col", 32'(col), 32'hE);
        chk("mrst_code", 32'(keypadInput), 32'h0);
        chk("mrst_evt", 32'(keyPressEvent), 32'h0);
        chk("mrst_held", 32'(keyHeld), 32'h0);
        @(negedge clk);
        rst = 1'b0;
        watch(4, m);
        chk("mrst_rot_mask", m, 32'h0);
        chk("mrst_rot_col", 32'(col), 32'hD);
        watch(16, m);
        chk("mrst_quiet", m, 32'h0);
`endif
        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
